decode_stage: RTL and testbench

Instruction-decode stage of the no-forwarding 5-stage MIPS-Lite pipeline. It sits between fetch and the execution stage. It decodes the fetched word and reads the 32×32 register file (write-through from writeback). It detects RAW hazards against the two in-flight older instructions, stalls fetch and inserts bubbles. Each cycle it registers one issued instruction, or a bubble, into the ID/EX pipeline register that drives the execution stage.

---
 rtl/mips_pkg.sv | 133 +++++++++++++
 rtl/reg_file.sv | 43 ++++
 rtl/decode_stage.sv | 129 ++++++++++++
 tb/tb_decode_stage.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS-Lite pipeline.
//   DATA / ADDRESSWIDTH / REGISTERWIDTH  datapath, PC and register-index widths
//   opcode_t   6-bit primary opcode encoding
//   alu_op_t   ALU operation carried to EX
//   Control    control bundle registered into ID/EX
//   Instruct   decoded instruction fields registered into ID/EX
//   dec_t      per-opcode decode result (operand usage + control)
//   decode_op  opcode -> dec_t lookup
package mips_pkg;

  localparam int DATA          = 32;
  localparam int ADDRESSWIDTH  = 32;
  localparam int REGISTERWIDTH = 5;

  typedef enum logic [5:0] {
    OP_ADD  = 6'd0,
    OP_SUB  = 6'd1,
    OP_MUL  = 6'd2,
    OP_OR   = 6'd3,
    OP_AND  = 6'd4,
    OP_XOR  = 6'd5,
    OP_ADDI = 6'd6,
    OP_SUBI = 6'd7,
    OP_MULI = 6'd8,
    OP_ORI  = 6'd9,
    OP_ANDI = 6'd10,
    OP_XORI = 6'd11,
    OP_LDW  = 6'd12,
    OP_STW  = 6'd13,
    OP_BZ   = 6'd14,
    OP_BEQ  = 6'd15,
    OP_JR   = 6'd16,
    OP_HALT = 6'd17
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_MUL = 3'd2,
    ALU_OR  = 3'd3,
    ALU_AND = 3'd4,
    ALU_XOR = 3'd5
  } alu_op_t;

  typedef struct packed {
    alu_op_t aluOp;
    logic    rs2;       // second ALU operand is immOut instead of readData2
    logic    regWrite;
    logic    memRead;
    logic    memWrite;
    logic    memToReg;
    logic    branch;
    logic    jump;
    logic    halt;
  } Control;

  typedef struct packed {
    opcode_t                  opcode;
    logic [REGISTERWIDTH-1:0] rs;
    logic [REGISTERWIDTH-1:0] rt;
    logic [REGISTERWIDTH-1:0] rd;
    logic [15:0]              imm;
  } Instruct;

  typedef struct packed {
    logic   known;     // opcode is defined
    logic   use_rs;
    logic   use_rt;
    logic   dest_rt;   // destination is rt (I-type / LDW) rather than rd
    Control cntrl;
  } dec_t;

  localparam Control BUBBLE = '0;

  function automatic dec_t decode_op(input logic [5:0] op);
    dec_t d;
    d       = '0;
    d.known = 1'b1;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR: begin
        d.use_rs         = 1'b1;
        d.use_rt         = 1'b1;
        d.cntrl.regWrite = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI: begin
        d.use_rs         = 1'b1;
        d.dest_rt        = 1'b1;
        d.cntrl.regWrite = 1'b1;
        d.cntrl.rs2      = 1'b1;
      end
      OP_LDW: begin
        d.use_rs         = 1'b1;
        d.dest_rt        = 1'b1;
        d.cntrl.regWrite = 1'b1;
        d.cntrl.rs2      = 1'b1;
        d.cntrl.memRead  = 1'b1;
        d.cntrl.memToReg = 1'b1;
      end
      OP_STW: begin
        // address = rs + imm, store data = rt
        d.use_rs         = 1'b1;
        d.use_rt         = 1'b1;
        d.cntrl.rs2      = 1'b1;
        d.cntrl.memWrite = 1'b1;
      end
      OP_BZ: begin
        d.use_rs       = 1'b1;
        d.cntrl.branch = 1'b1;
      end
      OP_BEQ: begin
        d.use_rs       = 1'b1;
        d.use_rt       = 1'b1;
        d.cntrl.branch = 1'b1;
      end
      OP_JR: begin
        d.use_rs     = 1'b1;
        d.cntrl.jump = 1'b1;
      end
      OP_HALT: d.cntrl.halt = 1'b1;
      default: d.known = 1'b0;
    endcase
    case (op)
      OP_SUB, OP_SUBI: d.cntrl.aluOp = ALU_SUB;
      OP_MUL, OP_MULI: d.cntrl.aluOp = ALU_MUL;
      OP_OR,  OP_ORI:  d.cntrl.aluOp = ALU_OR;
      OP_AND, OP_ANDI: d.cntrl.aluOp = ALU_AND;
      OP_XOR, OP_XORI: d.cntrl.aluOp = ALU_XOR;
      default:         d.cntrl.aluOp = ALU_ADD;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/reg_file.sv
// reg_file: 32 x DATA register file.
//   clk, rst_n   clock, asynchronous active-low clear of every register
//   ra1 / rd1    read port 1 (combinational)
//   ra2 / rd2    read port 2 (combinational)
//   we, wa, wd   synchronous write port
// r0 always reads 0 and ignores writes. A read of the register being written
// this cycle returns the write data (write-through).
module reg_file
  import mips_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [REGISTERWIDTH-1:0] ra1,
  input  logic [REGISTERWIDTH-1:0] ra2,
  output logic [DATA-1:0]          rd1,
  output logic [DATA-1:0]          rd2,
  input  logic                     we,
  input  logic [REGISTERWIDTH-1:0] wa,
  input  logic [DATA-1:0]          wd
);

  logic [DATA-1:0] regs [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  function automatic logic [DATA-1:0] read_port(input logic [REGISTERWIDTH-1:0] a);
    if (a == '0)             return '0;
    else if (we && wa == a)  return wd;
    else                     return regs[a];
  endfunction

  always_comb begin
    rd1 = read_port(ra1);
    rd2 = read_port(ra2);
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction decode for the no-forwarding 5-stage MIPS-Lite pipe.
//   clk, rst_n                  clock, asynchronous active-low reset
//   ifInstruction/ifPcPlus4/ifValid  word from fetch (held while stall=1)
//   flush                       taken branch/jump in EX squashes decode
//   wbWe/wbRd/wbData            writeback port into the register file
//   stall                       combinational: fetch holds PC and word
//   instruction, decoderRd, readData1, readData2, immOut, pcPlus4, cntrl,
//   idValid                     ID/EX pipeline register
//   halted                      sticky, set when HALT issues
// Operands the opcode does not read are registered as zero.
module decode_stage
  import mips_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              ifInstruction,
  input  logic [ADDRESSWIDTH-1:0]  ifPcPlus4,
  input  logic                     ifValid,
  input  logic                     flush,
  input  logic                     wbWe,
  input  logic [REGISTERWIDTH-1:0] wbRd,
  input  logic [DATA-1:0]          wbData,
  output logic                     stall,
  output Instruct                  instruction,
  output logic [REGISTERWIDTH-1:0] decoderRd,
  output logic [DATA-1:0]          readData1,
  output logic [DATA-1:0]          readData2,
  output logic [DATA-1:0]          immOut,
  output logic [ADDRESSWIDTH-1:0]  pcPlus4,
  output Control                   cntrl,
  output logic                     idValid,
  output logic                     halted
);

  function automatic logic [DATA-1:0] sext16(input logic [15:0] v);
    return {{(DATA-16){v[15]}}, v};
  endfunction

  // A scoreboard entry is {regWrite, rd}; only a written nonzero register
  // can conflict with a source.
  function automatic logic conflicts(input logic [REGISTERWIDTH-1:0] src,
                                     input logic [REGISTERWIDTH:0]   sb);
    return sb[REGISTERWIDTH] && (src != '0) && (sb[REGISTERWIDTH-1:0] == src);
  endfunction

  logic [REGISTERWIDTH-1:0] rs, rt, rd;
  logic [15:0]              imm;
  dec_t                     dec;
  logic [REGISTERWIDTH-1:0] dest;
  logic [DATA-1:0]          rf_rs, rf_rt;
  logic [REGISTERWIDTH:0]   ex_dest, mem_dest;
  logic                     hazard, issue;
  Instruct                  dec_instr;

  assign rs  = ifInstruction[25:21];
  assign rt  = ifInstruction[20:16];
  assign rd  = ifInstruction[15:11];
  assign imm = ifInstruction[15:0];
  assign dec = decode_op(ifInstruction[31:26]);

  always_comb begin
    dest = '0;
    if (dec.cntrl.regWrite) dest = dec.dest_rt ? rt : rd;
  end

  always_comb begin
    dec_instr        = '0;
    dec_instr.opcode = opcode_t'(ifInstruction[31:26]);
    dec_instr.rs     = rs;
    dec_instr.rt     = rt;
    dec_instr.rd     = rd;
    dec_instr.imm    = imm;
  end

  reg_file u_reg_file (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs),
    .rd1   (rf_rs),
    .ra2   (rt),
    .rd2   (rf_rt),
    .we    (wbWe),
    .wa    (wbRd),
    .wd    (wbData)
  );

  // Writeback is write-through, so only EX and MEM producers can conflict.
  always_comb begin
    hazard = 1'b0;
    if (ifValid && dec.known) begin
      if (dec.use_rs && (conflicts(rs, ex_dest) || conflicts(rs, mem_dest))) hazard = 1'b1;
      if (dec.use_rt && (conflicts(rt, ex_dest) || conflicts(rt, mem_dest))) hazard = 1'b1;
    end
  end

  // flush overrides everything; once halted, fetch is frozen for good.
  assign stall = !flush && (halted || hazard);
  assign issue = ifValid && dec.known && !flush && !halted && !hazard;

  // ID/EX boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_dest     <= '0;
      mem_dest    <= '0;
      halted      <= 1'b0;
      idValid     <= 1'b0;
      cntrl       <= BUBBLE;
      instruction <= '0;
      decoderRd   <= '0;
      readData1   <= '0;
      readData2   <= '0;
      immOut      <= '0;
      pcPlus4     <= '0;
    end else begin
      mem_dest    <= ex_dest;
      ex_dest     <= issue ? {dec.cntrl.regWrite, dest} : '0;
      idValid     <= issue;
      cntrl       <= issue ? dec.cntrl : BUBBLE;
      instruction <= issue ? dec_instr : '0;
      decoderRd   <= issue ? dest : '0;
      readData1   <= (issue && dec.use_rs) ? rf_rs : '0;
      readData2   <= (issue && dec.use_rt) ? rf_rt : '0;
      immOut      <= issue ? sext16(imm) : '0;
      pcPlus4     <= issue ? ifPcPlus4 : '0;
      if (issue && dec.cntrl.halt) halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  import mips_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [31:0]              ifInstruction;
  logic [ADDRESSWIDTH-1:0]  ifPcPlus4;
  logic                     ifValid;
  logic                     flush;
  logic                     wbWe;
  logic [REGISTERWIDTH-1:0] wbRd;
  logic [DATA-1:0]          wbData;
  logic                     stall;
  Instruct                  instruction;
  logic [REGISTERWIDTH-1:0] decoderRd;
  logic [DATA-1:0]          readData1, readData2, immOut;
  logic [ADDRESSWIDTH-1:0]  pcPlus4;
  Control                   cntrl;
  logic                     idValid, halted;

  int checks = 0;
  int failures = 0;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .ifInstruction(ifInstruction), .ifPcPlus4(ifPcPlus4),
    .ifValid(ifValid), .flush(flush), .wbWe(wbWe), .wbRd(wbRd), .wbData(wbData),
    .stall(stall), .instruction(instruction), .decoderRd(decoderRd),
    .readData1(readData1), .readData2(readData2), .immOut(immOut), .pcPlus4(pcPlus4),
    .cntrl(cntrl), .idValid(idValid), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  localparam int C_UNDEF = 0, C_R = 1, C_I = 2, C_LD = 3, C_ST = 4,
                 C_BZ = 5, C_BEQ = 6, C_JR = 7, C_HALT = 8;

  logic [DATA-1:0] mregs [32];
  int              m_last [2];     // destinations issued 1 and 2 cycles ago, -1 = none
  bit              m_halted;
  bit              e_valid;
  Control          e_cntrl;
  Instruct         e_instr;
  logic [4:0]      e_rd;
  logic [DATA-1:0] e_rd1, e_rd2, e_imm;
  logic [31:0]     e_pc;

  function automatic int m_class(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR:       return C_R;
      OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI: return C_I;
      OP_LDW:  return C_LD;
      OP_STW:  return C_ST;
      OP_BZ:   return C_BZ;
      OP_BEQ:  return C_BEQ;
      OP_JR:   return C_JR;
      OP_HALT: return C_HALT;
      default: return C_UNDEF;
    endcase
  endfunction

  function automatic bit m_reads_rs(input int k);
    return k == C_R || k == C_I || k == C_LD || k == C_ST || k == C_BZ || k == C_BEQ || k == C_JR;
  endfunction

  function automatic bit m_reads_rt(input int k);
    return k == C_R || k == C_ST || k == C_BEQ;
  endfunction

  function automatic int m_dest(input logic [31:0] w);
    int k;
    k = m_class(w[31:26]);
    if (k == C_R) return int'(w[15:11]);
    if (k == C_I || k == C_LD) return int'(w[20:16]);
    return -1;
  endfunction

  function automatic Control m_ctrl(input logic [5:0] op);
    Control c;
    int k;
    c = '0;
    k = m_class(op);
    c.rs2      = (k == C_I || k == C_LD || k == C_ST);
    c.regWrite = (k == C_R || k == C_I || k == C_LD);
    c.memRead  = (k == C_LD);
    c.memToReg = (k == C_LD);
    c.memWrite = (k == C_ST);
    c.branch   = (k == C_BZ || k == C_BEQ);
    c.jump     = (k == C_JR);
    c.halt     = (k == C_HALT);
    case (op)
      OP_SUB, OP_SUBI: c.aluOp = ALU_SUB;
      OP_MUL, OP_MULI: c.aluOp = ALU_MUL;
      OP_OR, OP_ORI:   c.aluOp = ALU_OR;
      OP_AND, OP_ANDI: c.aluOp = ALU_AND;
      OP_XOR, OP_XORI: c.aluOp = ALU_XOR;
      default:         c.aluOp = ALU_ADD;
    endcase
    return c;
  endfunction

  function automatic logic [DATA-1:0] m_read(input logic [4:0] r);
    if (r == 0) return '0;
    if (wbWe && wbRd == r) return wbData;
    return mregs[r];
  endfunction

  function automatic bit m_in_flight(input logic [4:0] r);
    return r != 0 && (int'(r) == m_last[0] || int'(r) == m_last[1]);
  endfunction

  function automatic bit m_hazard();
    int k;
    k = m_class(ifInstruction[31:26]);
    if (!ifValid || k == C_UNDEF) return 1'b0;
    return (m_reads_rs(k) && m_in_flight(ifInstruction[25:21])) ||
           (m_reads_rt(k) && m_in_flight(ifInstruction[20:16]));
  endfunction

  function automatic bit m_stall();
    if (flush) return 1'b0;
    return m_halted || m_hazard();
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    m_last[0] = -1; m_last[1] = -1;
    m_halted = 0;
    e_valid = 0; e_cntrl = '0; e_instr = '0; e_rd = '0;
    e_rd1 = '0; e_rd2 = '0; e_imm = '0; e_pc = '0;
  endtask

  // Advance one clock; the model computes its next state from the inputs
  // present before the edge.
  task automatic tick();
    int k, d;
    bit iss, w_we;
    logic [4:0] w_rd;
    logic [DATA-1:0] w_data;
    Instruct ni;
    k   = m_class(ifInstruction[31:26]);
    iss = ifValid && k != C_UNDEF && !flush && !m_halted && !m_hazard();
    d   = m_dest(ifInstruction);
    ni  = '0;
    if (iss) begin
      ni.opcode = opcode_t'(ifInstruction[31:26]);
      ni.rs = ifInstruction[25:21]; ni.rt = ifInstruction[20:16];
      ni.rd = ifInstruction[15:11]; ni.imm = ifInstruction[15:0];
    end
    w_we = wbWe; w_rd = wbRd; w_data = wbData;
    e_valid = iss;
    e_cntrl = iss ? m_ctrl(ifInstruction[31:26]) : '0;
    e_instr = ni;
    e_rd    = (iss && d >= 0) ? 5'(d) : 5'd0;
    e_rd1   = (iss && m_reads_rs(k)) ? m_read(ifInstruction[25:21]) : '0;
    e_rd2   = (iss && m_reads_rt(k)) ? m_read(ifInstruction[20:16]) : '0;
    e_imm   = iss ? {{16{ifInstruction[15]}}, ifInstruction[15:0]} : '0;
    e_pc    = iss ? ifPcPlus4 : '0;
    @(posedge clk);
    #1;
    m_last[1] = m_last[0];
    m_last[0] = iss ? d : -1;
    if (iss && k == C_HALT) m_halted = 1;
    if (w_we && w_rd != 0) mregs[w_rd] = w_data;
  endtask

  function automatic logic [31:0] r_word(input logic [5:0] op, input logic [4:0] s,
                                         input logic [4:0] t, input logic [4:0] d);
    return {op, s, t, d, 11'd0};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] s,
                                         input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  task automatic drive(input logic [31:0] w);
    ifInstruction = w;
    ifValid = 1'b1;
    ifPcPlus4 = ifPcPlus4 + 32'd4;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; ifInstruction = '0; ifPcPlus4 = '0; ifValid = 1'b0;
    flush = 1'b0; wbWe = 1'b0; wbRd = '0; wbData = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks++; if (idValid !== 1'b0) begin failures++; $display("FAIL reset_idValid got=%0b exp=0", idValid); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    checks++; if (cntrl !== Control'('0) || instruction !== Instruct'('0)) begin
      failures++; $display("FAIL reset_ctrl cntrl=%h instr=%h exp=0", cntrl, instruction); end
    checks++; if ({decoderRd, readData1, readData2, immOut, pcPlus4, halted} !== '0) begin
      failures++; $display("FAIL reset_data rd=%0d d1=%h d2=%h imm=%h pc=%h halted=%0b exp=0",
                           decoderRd, readData1, readData2, immOut, pcPlus4, halted); end
    tick();
    checks++; if (idValid !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL idle_bubble idValid=%0b stall=%0b exp=0/0", idValid, stall); end
  endtask

  task automatic test_back_to_back();
    drive(r_word(OP_ADD, 5'd1, 5'd2, 5'd3));
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_first_stall got=%0b exp=0", stall); end
    tick();
    checks++; if (idValid !== 1'b1 || decoderRd !== 5'd3) begin
      failures++; $display("FAIL b2b_first_issue idValid=%0b rd=%0d exp=1/3", idValid, decoderRd); end
    drive(r_word(OP_ADD, 5'd3, 5'd3, 5'd4));
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL b2b_stall%0d got=%0b exp=1", c, stall); end
      tick();
      checks++; if (idValid !== 1'b0 || cntrl !== Control'('0)) begin
        failures++; $display("FAIL b2b_bubble%0d idValid=%0b cntrl=%h exp=0/0", c, idValid, cntrl); end
    end
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_release got=%0b exp=0", stall); end
    tick();
    checks++; if (idValid !== 1'b1 || decoderRd !== 5'd4) begin
      failures++; $display("FAIL b2b_second_issue idValid=%0b rd=%0d exp=1/4", idValid, decoderRd); end
  endtask

  task automatic test_distance2();
    drive(i_word(OP_ADDI, 5'd0, 5'd5, 16'd7));
    tick();
    checks++; if (immOut !== 32'd7 || decoderRd !== 5'd5 || cntrl.rs2 !== 1'b1) begin
      failures++; $display("FAIL addi_issue imm=%h rd=%0d rs2=%0b exp=7/5/1", immOut, decoderRd, cntrl.rs2); end
    drive(r_word(OP_ADD, 5'd1, 5'd2, 5'd7));
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL dist2_indep_stall got=%0b exp=0", stall); end
    tick();
    drive(r_word(OP_SUB, 5'd5, 5'd5, 5'd6));
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL dist2_stall got=%0b exp=1", stall); end
    tick();
    checks++; if (idValid !== 1'b0) begin failures++; $display("FAIL dist2_bubble idValid=%0b exp=0", idValid); end
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL dist2_release got=%0b exp=0", stall); end
    tick();
    checks++; if (idValid !== 1'b1 || decoderRd !== 5'd6 || cntrl.aluOp !== ALU_SUB) begin
      failures++; $display("FAIL dist2_issue idValid=%0b rd=%0d alu=%0d exp=1/6/1", idValid, decoderRd, cntrl.aluOp); end
    drive(i_word(OP_ADDI, 5'd1, 5'd8, 16'hFFFF));
    tick();
    checks++; if (immOut !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL imm_sext got=%h exp=ffffffff", immOut); end
  endtask

  task automatic test_writethrough();
    wbWe = 1'b1; wbRd = 5'd9; wbData = 32'hDEAD_BEEF;
    drive(r_word(OP_OR, 5'd9, 5'd0, 5'd1));
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL wt_stall got=%0b exp=0", stall); end
    tick();
    checks++; if (readData1 !== 32'hDEAD_BEEF || readData2 !== 32'd0) begin
      failures++; $display("FAIL wt_read d1=%h d2=%h exp=deadbeef/0", readData1, readData2); end
    wbWe = 1'b0;
    drive(r_word(OP_ADD, 5'd1, 5'd2, 5'd0));
    tick();
    drive(r_word(OP_ADD, 5'd0, 5'd0, 5'd10));
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL r0_no_hazard stall=%0b exp=0", stall); end
    tick();
    drive(r_word(OP_XOR, 5'd9, 5'd9, 5'd11));
    tick();
    checks++; if (readData1 !== 32'hDEAD_BEEF || readData2 !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL rf_stored d1=%h d2=%h exp=deadbeef", readData1, readData2); end
  endtask

  task automatic test_flush();
    drive(r_word(OP_ADD, 5'd1, 5'd2, 5'd12));
    tick();
    drive(r_word(OP_ADD, 5'd12, 5'd0, 5'd13));
    flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%0b exp=0", stall); end
    tick();
    flush = 1'b0;
    checks++; if (idValid !== 1'b0 || cntrl !== Control'('0)) begin
      failures++; $display("FAIL flush_bubble idValid=%0b cntrl=%h exp=0/0", idValid, cntrl); end
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL flush_sb_advance stall=%0b exp=1", stall); end
    tick();
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_release stall=%0b exp=0", stall); end
    tick();
    checks++; if (idValid !== 1'b1 || decoderRd !== 5'd13) begin
      failures++; $display("FAIL flush_reissue idValid=%0b rd=%0d exp=1/13", idValid, decoderRd); end
  endtask

  task automatic test_random();
    bit hold, es;
    logic [5:0] op;
    hold = 0;
    for (int n = 0; n < 500; n++) begin
      if (!hold) begin
        op = 6'($urandom_range(0, 16));              // every defined opcode but HALT
        if ($urandom_range(0, 15) == 0) op = 6'($urandom_range(18, 63));
        ifInstruction = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), 11'($urandom)};
        ifValid   = ($urandom_range(0, 9) != 0);
        ifPcPlus4 = $urandom;
      end
      flush  = ($urandom_range(0, 15) == 0);
      wbWe   = 1'($urandom_range(0, 1));
      wbRd   = 5'($urandom_range(0, 7));
      wbData = $urandom;
      #1;
      es = m_stall();
      checks++; if (stall !== es) begin
        failures++; $display("FAIL rnd_stall n=%0d got=%0b exp=%0b", n, stall, es); end
      hold = es;
      tick();
      checks++; if (idValid !== e_valid || cntrl !== e_cntrl || instruction !== e_instr) begin
        failures++; $display("FAIL rnd_ctrl n=%0d valid=%0b/%0b cntrl=%h/%h instr=%h/%h",
                             n, idValid, e_valid, cntrl, e_cntrl, instruction, e_instr); end
      checks++; if (decoderRd !== e_rd || readData1 !== e_rd1 || readData2 !== e_rd2 ||
                    immOut !== e_imm || pcPlus4 !== e_pc || halted !== 1'b0) begin
        failures++; $display("FAIL rnd_data n=%0d rd=%0d/%0d d1=%h/%h d2=%h/%h imm=%h/%h pc=%h/%h halted=%0b/0",
                             n, decoderRd, e_rd, readData1, e_rd1, readData2, e_rd2,
                             immOut, e_imm, pcPlus4, e_pc, halted); end
    end
    flush = 1'b0; wbWe = 1'b0;
  endtask

  task automatic test_halt_reset();
    drive(r_word(OP_ADD, 5'd20, 5'd21, 5'd22));
    tick();
    tick();
    tick();
    drive({OP_HALT, 26'd0});
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL halt_pre_stall got=%0b exp=0", stall); end
    tick();
    checks++; if (cntrl.halt !== 1'b1 || halted !== 1'b1 || idValid !== 1'b1) begin
      failures++; $display("FAIL halt_issue halt=%0b halted=%0b idValid=%0b exp=1/1/1", cntrl.halt, halted, idValid); end
    drive(r_word(OP_ADD, 5'd2, 5'd3, 5'd1));
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL halted_stall got=%0b exp=1", stall); end
    tick();
    checks++; if (idValid !== 1'b0 || cntrl.halt !== 1'b0 || halted !== 1'b1) begin
      failures++; $display("FAIL halted_bubble idValid=%0b halt=%0b halted=%0b exp=0/0/1", idValid, cntrl.halt, halted); end
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL halted_sticky_stall got=%0b exp=1", stall); end
    #1;
    rst_n = 1'b0;
    #1;
    m_reset();
    checks++; if (stall !== 1'b0 || halted !== 1'b0 || idValid !== 1'b0) begin
      failures++; $display("FAIL async_reset stall=%0b halted=%0b idValid=%0b exp=0", stall, halted, idValid); end
    checks++; if (cntrl !== Control'('0) || instruction !== Instruct'('0) || pcPlus4 !== '0) begin
      failures++; $display("FAIL async_reset_regs cntrl=%h instr=%h pc=%h exp=0", cntrl, instruction, pcPlus4); end
    #3;
    rst_n = 1'b1;
    drive(r_word(OP_ADD, 5'd2, 5'd3, 5'd1));
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL post_reset_stall got=%0b exp=0", stall); end
    tick();
    checks++; if (idValid !== 1'b1 || decoderRd !== 5'd1) begin
      failures++; $display("FAIL post_reset_issue idValid=%0b rd=%0d exp=1/1", idValid, decoderRd); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_distance2();
    test_writethrough();
    test_flush();
    test_random();
    test_halt_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
